br_resolve_sched: RTL and testbench
===================================

BR_RESOLVE_SCHED -- requirements
Module: br_resolve_sched

Interface
REQ-001 SHALL have parameter: BR_MASK_W, 5, branch mask width (one bit per in-flight branch).
REQ-002 SHALL have parameter: NUM_SRC, 2, number of branch-resolving execution units.
REQ-003 SHALL have parameter: Q_DEPTH, 4, depth of the correct-resolution queue (power of two, ≥ NUM_SRC).
REQ-004 SHALL have port: clk  in  1  clock.
REQ-005 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port: res_valid_i  in  NUM_SRC  per-source resolution valid.
REQ-007 SHALL have port: res_wrong_i  in  NUM_SRC  per-source mispredict flag (1 = wrong, 0 = correct).
REQ-008 SHALL have port: res_bit_i  in  NUM_SRC*BR_MASK_W  per-source one-hot bit of the resolved branch.
REQ-009 SHALL have port: res_mask_i  in  NUM_SRC*BR_MASK_W  per-source dependency mask of the resolved branch.
REQ-010 SHALL have port: br_state_o  out  `BR_STATE_W  resolution event to the mask controller: `BR_PR_WRONG, `BR_PR_CORRECT, or idle (all zeros).
REQ-011 SHALL have port: br_bit_o  out  BR_MASK_W  one-hot bit of the issued resolution.
REQ-012 SHALL have port: br_mask_o  out  BR_MASK_W  dependency mask of the issued resolution.
REQ-013 SHALL have port: stall_o  out  1  backpressure to the branch units.
REQ-014 SHALL have port: q_count_o  out  $clog2(Q_DEPTH)+1  queue occupancy.

Function
REQ-015 Outputs SHALL be registered and SHALL carry at most one resolution per cycle.
REQ-016 A valid wrong input SHALL be issued on the next cycle; it takes priority over all queued or incoming correct resolutions.
REQ-017 If more than one wrong input is valid, the scheduler SHALL issue the oldest: the source whose res_mask_i contains none of the other wrong sources' res_bit_i. Ties SHALL go to the lowest index.
REQ-018 Non-issued wrong inputs in the same cycle SHALL be dropped; they are younger than the issued wrong and are squashed by it.
REQ-019 Each valid correct input SHALL be pushed into the FIFO queue, lower source index first, unless squashed per REQ-020.
REQ-020 When a wrong with bit B is issued, every queued entry and every same-cycle correct input whose mask has bit B set SHALL be discarded; the queue SHALL be compacted with order preserved, and q_count SHALL be updated in the same cycle.
REQ-021 When no wrong is issued and the queue is non-empty, the head SHALL be popped and issued as `BR_PR_CORRECT, with latency ≥ 2 cycles from input.
REQ-022 When a correct with bit B is issued, bit B SHALL be cleared in the mask of every remaining queue entry and every same-cycle correct input.
REQ-023 Issuing and pushing in the same cycle SHALL be allowed; q_count = old + pushes − pops − squashes.
REQ-024 stall_o SHALL be registered and asserted while q_count > Q_DEPTH − NUM_SRC, which guarantees no overflow.
REQ-025 Valid inputs arriving while stall_o=1 are a protocol violation; the block SHALL drop excess pushes when full and SHALL never corrupt entries.
REQ-026 In idle cycles, br_state_o, br_bit_o and br_mask_o SHALL be 0.

Reset
REQ-027 rst SHALL clear the queue; br_state_o, br_bit_o, br_mask_o, stall_o and q_count_o SHALL all be 0 on the cycle after rst.
REQ-028 Inputs presented during rst SHALL be ignored; a rst asserted mid-operation SHALL discard all pending entries.

Configuration
REQ-029 Macro BR_RESOLVE_BYPASS_EN, when defined: a single correct input arriving with an empty queue and no wrong that cycle SHALL be issued on the next cycle without entering the queue.
REQ-030 Without BR_RESOLVE_BYPASS_EN, all correct resolutions SHALL pass through the queue, giving a minimum latency of 2 cycles.

Verification
REQ-031 Src0 correct, bit 5'b00010, mask 0, queue empty -> `BR_PR_CORRECT with bit 00010 at cycle +2 (+1 with bypass); q_count returns to 0.
REQ-032 Both sources wrong: src0 bit 00100 mask 00001; src1 bit 00001 mask 0 -> src1 issued `BR_PR_WRONG with bit 00001 next cycle; src0 dropped.
REQ-033 Queue holds corrects {bit 00010, mask 00001} and {bit 01000, mask 0}; wrong bit 00001 arrives -> WRONG issued, first entry squashed, q_count = 1, then CORRECT 01000.
REQ-034 Queue holds {bit 00100, mask 00010}; CORRECT bit 00010 issued -> remaining entry mask becomes 0.
REQ-035 With Q_DEPTH=4, push 3 corrects with no pops possible (wrongs held each cycle) -> stall_o=1 once q_count=3; no entry is lost.
REQ-036 Assert rst with q_count=3 -> all outputs 0 on the next cycle; a subsequent correct input behaves as in REQ-031.

Source files
------------

// File: rtl/br_resolve_sched.sv
// Branch-resolution scheduler: issues one wrong/correct resolution per cycle to the mask controller.
// Optional macro BR_RESOLVE_BYPASS_EN lets a lone correct skip an empty queue for 1-cycle latency.
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'b10
`endif

module br_resolve_sched #(
  parameter int BR_MASK_W = 5,
  parameter int NUM_SRC   = 2,
  parameter int Q_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             res_valid_i,
  input  logic [NUM_SRC-1:0]             res_wrong_i,
  input  logic [NUM_SRC*BR_MASK_W-1:0]   res_bit_i,
  input  logic [NUM_SRC*BR_MASK_W-1:0]   res_mask_i,
  output logic [`BR_STATE_W-1:0]         br_state_o,
  output logic [BR_MASK_W-1:0]           br_bit_o,
  output logic [BR_MASK_W-1:0]           br_mask_o,
  output logic                           stall_o,
  output logic [$clog2(Q_DEPTH):0]       q_count_o
);
  localparam int CW = $clog2(Q_DEPTH) + 1;
  localparam logic [CW-1:0] QD       = CW'(Q_DEPTH);
  localparam logic [CW-1:0] STALL_TH = CW'(Q_DEPTH - NUM_SRC);

  logic [BR_MASK_W-1:0] q_bit_q  [Q_DEPTH];
  logic [BR_MASK_W-1:0] q_mask_q [Q_DEPTH];
  logic [BR_MASK_W-1:0] q_bit_d  [Q_DEPTH];
  logic [BR_MASK_W-1:0] q_mask_d [Q_DEPTH];
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 stall_q;
  logic [`BR_STATE_W-1:0] state_q, state_d;
  logic [BR_MASK_W-1:0] bit_q, bit_d, mask_q, mask_d;

  logic [NUM_SRC-1:0]   vw, vc;
  logic                 wr_any, wr_found, pop, byp;
  logic [BR_MASK_W-1:0] wr_bit, wr_mask, byp_bit, byp_mask, sq_bit, clr_bit;
  logic [CW-1:0]        n;

  assign vw = res_valid_i & res_wrong_i;
  assign vc = res_valid_i & ~res_wrong_i;
  assign wr_any = |vw;
  assign pop = !wr_any && (cnt_q != '0);

`ifdef BR_RESOLVE_BYPASS_EN
  assign byp = !wr_any && (cnt_q == '0) && (vc != '0) && ((vc & (vc - 1'b1)) == '0);
`else
  assign byp = 1'b0;
`endif

  // Oldest wrong: its mask depends on no other same-cycle wrong; fallback is lowest index.
  always_comb begin
    logic older;
    wr_found = 1'b0;
    wr_bit   = '0;
    wr_mask  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vw[i]) begin
        wr_bit  = res_bit_i[i*BR_MASK_W +: BR_MASK_W];
        wr_mask = res_mask_i[i*BR_MASK_W +: BR_MASK_W];
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      older = 1'b1;
      for (int j = 0; j < NUM_SRC; j++) begin
        if (j != i && vw[j] &&
            ((res_mask_i[i*BR_MASK_W +: BR_MASK_W] & res_bit_i[j*BR_MASK_W +: BR_MASK_W]) != '0))
          older = 1'b0;
      end
      if (vw[i] && older && !wr_found) begin
        wr_found = 1'b1;
        wr_bit   = res_bit_i[i*BR_MASK_W +: BR_MASK_W];
        wr_mask  = res_mask_i[i*BR_MASK_W +: BR_MASK_W];
      end
    end
  end

  always_comb begin
    byp_bit  = '0;
    byp_mask = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vc[i]) begin
        byp_bit  = res_bit_i[i*BR_MASK_W +: BR_MASK_W];
        byp_mask = res_mask_i[i*BR_MASK_W +: BR_MASK_W];
      end
    end
  end

  assign sq_bit  = wr_any ? wr_bit : '0;
  assign clr_bit = pop ? q_bit_q[0] : '0;

  // Compact survivors to the front (order kept), then append same-cycle corrects.
  always_comb begin
    n = '0;
    for (int k = 0; k < Q_DEPTH; k++) begin
      q_bit_d[k]  = '0;
      q_mask_d[k] = '0;
    end
    for (int k = 0; k < Q_DEPTH; k++) begin
      if ((CW'(k) < cnt_q) && !(pop && k == 0) && ((q_mask_q[k] & sq_bit) == '0)) begin
        q_bit_d[n[CW-2:0]]  = q_bit_q[k];
        q_mask_d[n[CW-2:0]] = q_mask_q[k] & ~clr_bit;
        n = n + CW'(1);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (vc[i] && !byp && ((res_mask_i[i*BR_MASK_W +: BR_MASK_W] & sq_bit) == '0) && (n < QD)) begin
        q_bit_d[n[CW-2:0]]  = res_bit_i[i*BR_MASK_W +: BR_MASK_W];
        q_mask_d[n[CW-2:0]] = res_mask_i[i*BR_MASK_W +: BR_MASK_W] & ~clr_bit;
        n = n + CW'(1);
      end
    end
    cnt_d = n;
  end

  always_comb begin
    state_d = '0;
    bit_d   = '0;
    mask_d  = '0;
    if (wr_any) begin
      state_d = `BR_PR_WRONG;
      bit_d   = wr_bit;
      mask_d  = wr_mask;
    end else if (pop) begin
      state_d = `BR_PR_CORRECT;
      bit_d   = q_bit_q[0];
      mask_d  = q_mask_q[0];
    end else if (byp) begin
      state_d = `BR_PR_CORRECT;
      bit_d   = byp_bit;
      mask_d  = byp_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      stall_q <= 1'b0;
      state_q <= '0;
      bit_q   <= '0;
      mask_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= (cnt_d > STALL_TH);
      state_q <= state_d;
      bit_q   <= bit_d;
      mask_q  <= mask_d;
    end
  end

  // Entry payload needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    for (int k = 0; k < Q_DEPTH; k++) begin
      q_bit_q[k]  <= q_bit_d[k];
      q_mask_q[k] <= q_mask_d[k];
    end
  end

  assign br_state_o = state_q;
  assign br_bit_o   = bit_q;
  assign br_mask_o  = mask_q;
  assign stall_o    = stall_q;
  assign q_count_o  = cnt_q;
endmodule

// File: tb/tb_br_resolve_sched.sv
// Directed bench for br_resolve_sched; observed outputs packed as {state,bit,mask,count,stall}.
`timescale 1ns/1ps
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'b10
`endif

module tb_br_resolve_sched;
  localparam int W = 5;
  localparam int NS = 2;
  localparam int QD = 4;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] COR  = `BR_PR_CORRECT;
  localparam logic [1:0] WRG  = `BR_PR_WRONG;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] res_valid = '0, res_wrong = '0;
  logic [NS*W-1:0] res_bit = '0, res_mask = '0;
  logic [1:0]    br_state;
  logic [W-1:0]  br_bit, br_mask;
  logic          stall;
  logic [2:0]    q_count;
  logic [15:0]   obs;
  int checks = 0;
  int failures = 0;

  assign obs = {br_state, br_bit, br_mask, q_count, stall};

  br_resolve_sched #(.BR_MASK_W(W), .NUM_SRC(NS), .Q_DEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .res_valid_i(res_valid), .res_wrong_i(res_wrong),
    .res_bit_i(res_bit), .res_mask_i(res_mask),
    .br_state_o(br_state), .br_bit_o(br_bit), .br_mask_o(br_mask),
    .stall_o(stall), .q_count_o(q_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic v, input logic wr, input logic [W-1:0] b, input logic [W-1:0] m);
    res_valid[s] = v;
    res_wrong[s] = wr;
    res_bit[s*W +: W] = b;
    res_mask[s*W +: W] = m;
  endtask

  task automatic clear_in();
    res_valid = '0; res_wrong = '0; res_bit = '0; res_mask = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 5'b00100, 5'b0);
    drive(1, 1'b1, 1'b0, 5'b00010, 5'b0);
    tick(); tick();
    checks++;
    if (obs !== {IDLE, 5'b0, 5'b0, 3'd0, 1'b0}) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", obs, {IDLE, 5'b0, 5'b0, 3'd0, 1'b0});
    end
    rst = 1'b0;
    clear_in();
    tick();
    checks++;
    if (obs !== 16'h0) begin
      failures++; $display("FAIL reset_inputs_ignored got=%h exp=%h", obs, 16'h0);
    end
  endtask

  task automatic test_basic();
    drive(0, 1'b1, 1'b0, 5'b00010, 5'b0);
    tick();
    clear_in();
`ifdef BR_RESOLVE_BYPASS_EN
    checks++;
    if (obs !== {COR, 5'b00010, 5'b0, 3'd0, 1'b0}) begin
      failures++; $display("FAIL basic_bypass got=%h exp=%h", obs, {COR, 5'b00010, 5'b0, 3'd0, 1'b0});
    end
    tick();
    checks++;
    if (obs !== 16'h0) begin
      failures++; $display("FAIL basic_idle got=%h exp=%h", obs, 16'h0);
    end
`else
    checks++;
    if (obs !== {IDLE, 5'b0, 5'b0, 3'd1, 1'b0}) begin
      failures++; $display("FAIL basic_queued got=%h exp=%h", obs, {IDLE, 5'b0, 5'b0, 3'd1, 1'b0});
    end
    tick();
    checks++;
    if (obs !== {COR, 5'b00010, 5'b0, 3'd0, 1'b0}) begin
      failures++; $display("FAIL basic_pop got=%h exp=%h", obs, {COR, 5'b00010, 5'b0, 3'd0, 1'b0});
    end
`endif
    tick();
    checks++;
    if (obs !== 16'h0) begin
      failures++; $display("FAIL basic_after got=%h exp=%h", obs, 16'h0);
    end
  endtask

  task automatic test_wrong_pick();
    drive(0, 1'b1, 1'b1, 5'b00100, 5'b00001);
    drive(1, 1'b1, 1'b1, 5'b00001, 5'b00000);
    tick();
    clear_in();
    checks++;
    if (obs !== {WRG, 5'b00001, 5'b0, 3'd0, 1'b0}) begin
      failures++; $display("FAIL wrong_oldest got=%h exp=%h", obs, {WRG, 5'b00001, 5'b0, 3'd0, 1'b0});
    end
    tick();
    checks++;
    if (obs !== 16'h0) begin
      failures++; $display("FAIL wrong_dropped got=%h exp=%h", obs, 16'h0);
    end
    // Neither wrong is older than the other: lowest index wins.
    drive(0, 1'b1, 1'b1, 5'b01000, 5'b00000);
    drive(1, 1'b1, 1'b1, 5'b10000, 5'b00000);
    tick();
    clear_in();
    checks++;
    if (obs !== {WRG, 5'b01000, 5'b0, 3'd0, 1'b0}) begin
      failures++; $display("FAIL wrong_tie got=%h exp=%h", obs, {WRG, 5'b01000, 5'b0, 3'd0, 1'b0});
    end
    tick();
  endtask

  task automatic test_squash();
    drive(0, 1'b1, 1'b0, 5'b00010, 5'b00001);
    drive(1, 1'b1, 1'b0, 5'b01000, 5'b00000);
    tick();
    checks++;
    if (obs !== {IDLE, 5'b0, 5'b0, 3'd2, 1'b0}) begin
      failures++; $display("FAIL squash_fill got=%h exp=%h", obs, {IDLE, 5'b0, 5'b0, 3'd2, 1'b0});
    end
    clear_in();
    drive(0, 1'b1, 1'b1, 5'b00001, 5'b00000);
    tick();
    clear_in();
    checks++;
    if (obs !== {WRG, 5'b00001, 5'b0, 3'd1, 1'b0}) begin
      failures++; $display("FAIL squash_wrong got=%h exp=%h", obs, {WRG, 5'b00001, 5'b0, 3'd1, 1'b0});
    end
    tick();
    checks++;
    if (obs !== {COR, 5'b01000, 5'b0, 3'd0, 1'b0}) begin
      failures++; $display("FAIL squash_survivor got=%h exp=%h", obs, {COR, 5'b01000, 5'b0, 3'd0, 1'b0});
    end
    tick();
  endtask

  task automatic test_mask_clear();
    drive(0, 1'b1, 1'b0, 5'b00010, 5'b00000);
    drive(1, 1'b1, 1'b0, 5'b00100, 5'b00010);
    tick();
    clear_in();
    checks++;
    if (obs !== {IDLE, 5'b0, 5'b0, 3'd2, 1'b0}) begin
      failures++; $display("FAIL maskclr_fill got=%h exp=%h", obs, {IDLE, 5'b0, 5'b0, 3'd2, 1'b0});
    end
    tick();
    checks++;
    if (obs !== {COR, 5'b00010, 5'b0, 3'd1, 1'b0}) begin
      failures++; $display("FAIL maskclr_first got=%h exp=%h", obs, {COR, 5'b00010, 5'b0, 3'd1, 1'b0});
    end
    tick();
    checks++;
    if (obs !== {COR, 5'b00100, 5'b00000, 3'd0, 1'b0}) begin
      failures++; $display("FAIL maskclr_cleared got=%h exp=%h", obs, {COR, 5'b00100, 5'b00000, 3'd0, 1'b0});
    end
    tick();
  endtask

  task automatic fill_three();
    logic [W-1:0] b;
    logic [2:0]   c;
    for (int k = 0; k < 3; k++) begin
      b = 5'b00001 << k;
      c = 3'(k + 1);
      drive(0, 1'b1, 1'b1, 5'b10000, 5'b00000);
      drive(1, 1'b1, 1'b0, b, 5'b00000);
      tick();
      checks++;
      if (obs !== {WRG, 5'b10000, 5'b0, c, (k == 2)}) begin
        failures++; $display("FAIL stall_fill%0d got=%h exp=%h", k, obs, {WRG, 5'b10000, 5'b0, c, (k == 2)});
      end
    end
    clear_in();
  endtask

  task automatic test_stall();
    logic [W-1:0] b;
    logic [2:0]   c;
    fill_three();
    for (int k = 0; k < 3; k++) begin
      tick();
      b = 5'b00001 << k;
      c = 3'(2 - k);
      checks++;
      if (obs !== {COR, b, 5'b0, c, 1'b0}) begin
        failures++; $display("FAIL stall_drain%0d got=%h exp=%h", k, obs, {COR, b, 5'b0, c, 1'b0});
      end
    end
    tick();
  endtask

  task automatic test_rst_mid();
    fill_three();
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 5'b00100, 5'b0);
    tick();
    rst = 1'b0;
    clear_in();
    checks++;
    if (obs !== 16'h0) begin
      failures++; $display("FAIL rst_mid got=%h exp=%h", obs, 16'h0);
    end
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrong_pick();
    test_squash();
    test_mask_clear();
    test_stall();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
